sump_cmd_engine: RTL and testbench
==================================

SUMP_CMD_ENGINE -- requirements
Module: sump_cmd_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 8: command queue depth in entries, power of two, at least 2.
REQ-002 SHALL have parameter VALUE_BYTES, default 4: long-command value length in bytes, 1..8.
REQ-003 SHALL have parameter PAD_BYTE, default 8'h7F: byte sent while the target holds data_ready.
REQ-004 SHALL have parameter TIMEOUT, default 65536: maximum cycles waiting for data_ready, at least 2.
REQ-005 SHALL have ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept.
- cmd_opcode  in  8  SUMP opcode.
- cmd_value  in  8*VALUE_BYTES  long-command value.
- cmd_long  in  1  1 = send value bytes after opcode.
- cmd_wait  in  1  1 = perform data_ready/pad handshake after command.
- tx_valid  out  1  byte offered to the UART transmitter.
- tx_ready  in  1  transmitter accepts.
- tx_data  out  8  byte.
- data_ready  in  1  target dataReady, asynchronous.
- clr_err  in  1  clears timeout_err.
- busy  out  1  queue non-empty or state not IDLE.
- timeout_err  out  1  sticky wait timeout.
- pad_count  out  16  pad bytes sent in the most recent wait.

Function
REQ-006 SHALL pass data_ready through a 2-flop synchroniser (drs); all decisions use drs.
REQ-007 SHALL queue accepted commands in a DEPTH-entry FIFO; cmd_ready = not full; accept on cmd_valid & cmd_ready.
REQ-008 SHALL provide no fall-through: a command pushed into an empty queue is popped no earlier than the next edge.
REQ-009 SHALL discard cmd_valid while full; queue contents are unchanged.
REQ-010 SHALL implement states IDLE, OPC, VAL, WAIT_RDY, PAD.
REQ-011 IDLE: if the queue is non-empty, SHALL pop one entry into holding registers and go to OPC.
REQ-012 Latency: for a command accepted at edge E into an empty idle engine, tx_valid SHALL rise after edge E+2.
REQ-013 OPC SHALL drive tx_data = opcode. On handshake: cmd_long -> VAL with index 0; otherwise cmd_wait -> WAIT_RDY; otherwise IDLE.
REQ-014 VAL SHALL send value bytes LSB first, index 0..VALUE_BYTES-1. After the last handshake: cmd_wait -> WAIT_RDY, else IDLE.
REQ-015 Once tx_valid is high, tx_valid and tx_data SHALL stay stable until tx_ready is sampled high.
REQ-016 Entering WAIT_RDY SHALL clear pad_count and the wait counter. The counter increments each cycle.
REQ-017 WAIT_RDY: drs high -> PAD. If the counter reaches TIMEOUT-1 with drs low, SHALL set timeout_err and go to IDLE.
REQ-018 PAD SHALL drive tx_data = PAD_BYTE. Each handshake increments pad_count, saturating at 16'hFFFF.
REQ-019 PAD: after each handshake, drs low -> IDLE; else send another pad byte. At least one pad byte is always sent.
REQ-020 timeout_err SHALL stay set until clr_err is high at an edge. If set and clr_err occur in the same cycle, set wins.
REQ-021 busy SHALL be high when state is not IDLE or the queue is non-empty.

Reset
REQ-022 rst low SHALL immediately force state IDLE and the queue empty.
REQ-023 rst low SHALL clear tx_valid, tx_data, busy, timeout_err, pad_count and the synchroniser, with no clock required.
REQ-024 cmd_ready SHALL be 1 while rst is high and the queue is empty.
REQ-025 Reset mid-command SHALL drop the in-flight command and all queued commands. No bytes are emitted after release until new commands arrive.

Verification
REQ-026 Short command 8'h00, long=0, wait=0, tx_ready=1 -> exactly one byte 00; busy returns to 0 two cycles after the handshake.
REQ-027 Long command 8'h81, value 32'h00040004, with tx_ready toggling every cycle -> bytes 81,04,00,04,00 in order; tx_data stable during stalls.
REQ-028 Command 8'h02 with wait=1; data_ready raised 20 cycles after the opcode handshake and held for 3 pad handshakes -> bytes 02,7F,7F,7F; pad_count=3; then IDLE.
REQ-029 DEPTH=8, tx_ready=0, push 9 commands -> cmd_ready low after the 8th accept; the 9th is dropped; releasing tx_ready emits exactly 8 opcodes in order.
REQ-030 TIMEOUT=64, wait=1, data_ready stuck low -> timeout_err=1 after 64 WAIT_RDY cycles; the next queued command proceeds; clr_err pulse -> timeout_err=0.
REQ-031 rst pulled low during VAL index 2 -> tx_valid=0 and busy=0 immediately; after release, no bytes are emitted.

Source files
------------

// File: rtl/sump_cmd_engine.sv
// SUMP command engine: queues host commands and serialises them as UART bytes,
// with an optional dataReady/pad handshake guarded by a sticky timeout.
module sump_cmd_engine #(
  parameter int         DEPTH       = 8,
  parameter int         VALUE_BYTES = 4,
  parameter logic [7:0] PAD_BYTE    = 8'h7F,
  parameter int         TIMEOUT     = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_opcode,
  input  logic [8*VALUE_BYTES-1:0] cmd_value,
  input  logic                     cmd_long,
  input  logic                     cmd_wait,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  input  logic                     data_ready,
  input  logic                     clr_err,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              pad_count
);
  // state    | meaning
  // IDLE     | no command in flight; pops the queue when non-empty
  // OPC      | presenting the opcode byte
  // VAL      | presenting value bytes, LSB first
  // WAIT_RDY | waiting for synchronised dataReady, bounded by TIMEOUT
  // PAD      | sending PAD_BYTE while dataReady stays high
  typedef enum logic [2:0] {S_IDLE, S_OPC, S_VAL, S_WAIT_RDY, S_PAD} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int VW = 8 * VALUE_BYTES;
  localparam int EW = VW + 10;
  localparam int IW = (VALUE_BYTES > 1) ? $clog2(VALUE_BYTES) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_t          r_state, w_nxt_state;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic [EW-1:0]   w_rd_entry;
  logic            w_empty, w_full, w_push, w_pop, w_hs;
  logic [7:0]      r_opc;
  logic [VW-1:0]   r_val, w_val_sh;
  logic            r_long, r_wait;
  logic [IW-1:0]   r_idx, w_idx_nxt, w_idx_inc;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_drs_meta, r_drs;
  logic            r_tx_valid, w_nxt_tx_valid;
  logic [7:0]      r_tx_data, w_nxt_tx_data;
  logic            r_timeout_err;
  logic [15:0]     r_pad_count;
  logic            w_wait_clr, w_pad_inc, w_set_err;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = cmd_valid && !w_full;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  assign w_hs       = r_tx_valid && tx_ready;
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_val_sh   = r_val >> {w_idx_inc, 3'b000};

  assign cmd_ready   = !w_full;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign timeout_err = r_timeout_err;
  assign pad_count   = r_pad_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_value, cmd_long, cmd_wait};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_pop          = 1'b0;
    w_nxt_tx_valid = r_tx_valid;
    w_nxt_tx_data  = r_tx_data;
    w_idx_nxt      = r_idx;
    w_wait_clr     = 1'b0;
    w_pad_inc      = 1'b0;
    w_set_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_tx_valid = 1'b0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_state = S_OPC;
        end
      end
      S_OPC: begin
        // first OPC cycle only loads the byte, giving the two-edge issue latency
        if (!r_tx_valid) begin
          w_nxt_tx_valid = 1'b1;
          w_nxt_tx_data  = r_opc;
        end else if (w_hs) begin
          if (r_long) begin
            w_nxt_state   = S_VAL;
            w_idx_nxt     = '0;
            w_nxt_tx_data = r_val[7:0];
          end else if (r_wait) begin
            w_nxt_state    = S_WAIT_RDY;
            w_nxt_tx_valid = 1'b0;
            w_wait_clr     = 1'b1;
          end else begin
            w_nxt_state    = S_IDLE;
            w_nxt_tx_valid = 1'b0;
          end
        end
      end
      S_VAL: begin
        if (w_hs) begin
          if (r_idx == IW'(VALUE_BYTES - 1)) begin
            w_nxt_tx_valid = 1'b0;
            w_wait_clr     = r_wait;
            w_nxt_state    = r_wait ? S_WAIT_RDY : S_IDLE;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_nxt_tx_data = w_val_sh[7:0];
          end
        end
      end
      S_WAIT_RDY: begin
        w_nxt_tx_valid = 1'b0;
        if (r_drs) begin
          w_nxt_state    = S_PAD;
          w_nxt_tx_valid = 1'b1;
          w_nxt_tx_data  = PAD_BYTE;
        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
          w_set_err   = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      S_PAD: begin
        if (w_hs) begin
          w_pad_inc = 1'b1;
          if (!r_drs) begin
            w_nxt_state    = S_IDLE;
            w_nxt_tx_valid = 1'b0;
          end
        end
      end
      default: begin
        w_nxt_state    = S_IDLE;
        w_nxt_tx_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_opc         <= '0;
      r_val         <= '0;
      r_long        <= 1'b0;
      r_wait        <= 1'b0;
      r_idx         <= '0;
      r_wait_cnt    <= '0;
      r_drs_meta    <= 1'b0;
      r_drs         <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_timeout_err <= 1'b0;
      r_pad_count   <= '0;
    end else begin
      r_drs_meta <= data_ready;
      r_drs      <= r_drs_meta;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr                        <= r_rd_ptr + 1'b1;
        {r_opc, r_val, r_long, r_wait}  <= w_rd_entry;
      end
      r_idx      <= w_idx_nxt;
      r_tx_valid <= w_nxt_tx_valid;
      r_tx_data  <= w_nxt_tx_data;
      if (w_wait_clr)                  r_wait_cnt <= '0;
      else if (r_state == S_WAIT_RDY)  r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_wait_clr)                                 r_pad_count <= '0;
      else if (w_pad_inc && r_pad_count != 16'hFFFF)  r_pad_count <= r_pad_count + 1'b1;
      // a new timeout outranks a simultaneous clear
      if (w_set_err)    r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sump_cmd_engine.sv
// Directed bench for sump_cmd_engine: byte stream, latency, queue fill,
// pad handshake, timeout and mid-command reset.
module tb_sump_cmd_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_long, cmd_wait;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_value;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        data_ready, clr_err, busy, timeout_err;
  logic [15:0] pad_count;

  int errors = 0;
  int checks = 0;

  sump_cmd_engine #(.DEPTH(8), .VALUE_BYTES(4), .PAD_BYTE(8'h7F), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_value(cmd_value), .cmd_long(cmd_long),
    .cmd_wait(cmd_wait), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .data_ready(data_ready), .clr_err(clr_err), .busy(busy),
    .timeout_err(timeout_err), .pad_count(pad_count)
  );

  always #5 clk = ~clk;

  // byte collector and hold-stability monitor, sampled mid-cycle
  logic [7:0] q [$];
  int         stab_err = 0;
  int         stall_cnt = 0;
  logic       p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0] p_data = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        stall_cnt++;
        if (!tx_valid || tx_data !== p_data) stab_err++;
      end
      if (tx_valid && tx_ready) q.push_back(tx_data);
      p_valid = tx_valid;
      p_ready = tx_ready;
      p_data  = tx_data;
    end
  end

  function automatic logic [7:0] qb(input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  task automatic push_cmd(input logic [7:0] opc, input logic [31:0] val,
                          input logic lng, input logic wt);
    cmd_opcode = opc;
    cmd_value  = val;
    cmd_long   = lng;
    cmd_wait   = wt;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; cmd_valid = 0; cmd_opcode = 0; cmd_value = 0; cmd_long = 0;
    cmd_wait = 0; tx_ready = 0; data_ready = 0; clr_err = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (pad_count !== 16'h0) begin errors++; $display("FAIL reset_pad_count: got %h want 0000", pad_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_short;
    q.delete(); tx_ready = 1'b1;
    push_cmd(8'h00, 32'h0, 1'b0, 1'b0);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL short_lat_e0: got %b want 0", tx_valid); end
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL short_lat_e1: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL short_lat_e2: got %b want 1", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL short_data: got %h want 00", tx_data); end
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy_done: got %b want 0", busy); end
    repeat (4) @(posedge clk); #1;
    checks++; if (q.size() != 1) begin errors++; $display("FAIL short_count: got %0d want 1", q.size()); end
    checks++; if (qb(0) !== 8'h00) begin errors++; $display("FAIL short_byte: got %h want 00", qb(0)); end
  endtask

  task automatic test_long;
    logic [7:0] exp [5];
    exp = '{8'h81, 8'h04, 8'h00, 8'h04, 8'h00};
    q.delete(); tx_ready = 1'b0; stab_err = 0; stall_cnt = 0;
    push_cmd(8'h81, 32'h00040004, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tx_ready = ~tx_ready;
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++; if (q.size() != 5) begin errors++; $display("FAIL long_count: got %0d want 5", q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (qb(i) !== exp[i]) begin errors++; $display("FAIL long_byte%0d: got %h want %h", i, qb(i), exp[i]); end
    end
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL long_stalls: got %0d want >0", stall_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL long_stable: got %0d want 0", stab_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy: got %b want 0", busy); end
  endtask

  task automatic test_wait;
    int n;
    q.delete(); tx_ready = 1'b1; data_ready = 1'b0;
    push_cmd(8'h02, 32'h0, 1'b0, 1'b1);
    n = 0;
    while (q.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (q.size() != 1) begin errors++; $display("FAIL wait_opc_seen: got %0d want 1", q.size()); end
    repeat (20) @(posedge clk); #1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    data_ready = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (q.size() != 4) begin errors++; $display("FAIL wait_count: got %0d want 4", q.size()); end
    checks++; if (qb(0) !== 8'h02) begin errors++; $display("FAIL wait_opc: got %h want 02", qb(0)); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (qb(i) !== 8'h7F) begin errors++; $display("FAIL wait_pad%0d: got %h want 7f", i, qb(i)); end
    end
    checks++; if (pad_count !== 16'd3) begin errors++; $display("FAIL wait_pad_count: got %0d want 3", pad_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wait_no_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_fill;
    int   acc;
    logic rdy, rdy9;
    q.delete(); tx_ready = 1'b0; acc = 0; rdy9 = 1'b1;
    push_cmd(8'hA0, 32'h0, 1'b0, 1'b0);   // occupies the engine so the queue fills
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      cmd_opcode = 8'(8'h10 + i); cmd_long = 1'b0; cmd_wait = 1'b0; cmd_valid = 1'b1;
      @(negedge clk); rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
      if (i == 8) rdy9 = rdy;
    end
    cmd_valid = 1'b0;
    checks++; if (acc != 8) begin errors++; $display("FAIL fill_accepts: got %0d want 8", acc); end
    checks++; if (rdy9 !== 1'b0) begin errors++; $display("FAIL fill_ready_9th: got %b want 0", rdy9); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b want 0", cmd_ready); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL fill_no_tx: got %0d want 0", q.size()); end
    tx_ready = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks++; if (q.size() != 9) begin errors++; $display("FAIL fill_count: got %0d want 9", q.size()); end
    checks++; if (qb(0) !== 8'hA0) begin errors++; $display("FAIL fill_first: got %h want a0", qb(0)); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (qb(i + 1) !== 8'(8'h10 + i)) begin errors++; $display("FAIL fill_byte%0d: got %h want %h", i, qb(i + 1), 8'(8'h10 + i)); end
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_drained: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout;
    int n;
    q.delete(); tx_ready = 1'b1; data_ready = 1'b0;
    push_cmd(8'h03, 32'h0, 1'b0, 1'b1);
    push_cmd(8'h04, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (q.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (q.size() != 1) begin errors++; $display("FAIL to_opc_seen: got %0d want 1", q.size()); end
    n = 0;
    while (!timeout_err && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (n != 64) begin errors++; $display("FAIL to_cycles: got %0d want 64", n); end
    checks++; if (q.size() != 1) begin errors++; $display("FAIL to_no_pad: got %0d want 1", q.size()); end
    repeat (6) @(posedge clk); #1;
    checks++; if (qb(1) !== 8'h04) begin errors++; $display("FAIL to_next_cmd: got %h want 04", qb(1)); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    checks++; if (pad_count !== 16'd0) begin errors++; $display("FAIL to_pad_count: got %0d want 0", pad_count); end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid;
    int n;
    q.delete(); tx_ready = 1'b0;
    push_cmd(8'h81, 32'h44332211, 1'b1, 1'b0);
    push_cmd(8'h55, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    tx_ready = 1'b1;
    n = 0;
    while (q.size() < 3 && n < 20) begin @(posedge clk); #1; n++; end
    tx_ready = 1'b0;
    checks++; if (q.size() != 3) begin errors++; $display("FAIL rm_progress: got %0d want 3", q.size()); end
    checks++; if (tx_data !== 8'h33) begin errors++; $display("FAIL rm_val2: got %h want 33", tx_data); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rm_tx_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b1; tx_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++; if (q.size() != 3) begin errors++; $display("FAIL rm_silent: got %0d want 3", q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_after: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after: got %b want 1", cmd_ready); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_short();
    test_long();
    test_wait();
    test_fill();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
